// File: rtl/rx_datapath_pkg.sv
// Shared receive-side types and helpers for the UART rx datapath.
// Frame-format defaults live here so the transmitter and receiver agree on them.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

`ifndef PARITY_ODD
`define PARITY_ODD 0
`endif

package rx_datapath_pkg;

    localparam int unsigned DefaultDataWidth = `DATA_WIDTH;
    localparam int unsigned DefaultParityOdd = `PARITY_ODD;

    // True when the accumulated data parity plus the received parity bit
    // does not match the selected sense (0 = even, 1 = odd).
    function automatic logic parity_mismatch(input logic acc, input logic rx_bit,
                                             input logic odd);
        return (acc ^ rx_bit) != odd;
    endfunction

    // Holding-register next valid: a completed frame wins over a same-cycle transfer.
    function automatic logic next_valid(input logic valid, input logic ready,
                                        input logic load);
        logic nv;
        nv = valid;
        if (load) begin
            nv = 1'b1;
        end else if (valid && ready) begin
            nv = 1'b0;
        end
        return nv;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus a one-cycle-delayed
// copy used to detect the high-to-low start edge.

module uart_rx_sync (
    input  logic rx_clk,
    input  logic resetn,
    input  logic rx_serial,
    output logic rx_sync,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Line idles high, so reset every stage to 1 to avoid a false start edge.
    always_ff @(posedge rx_clk) begin
        if (!resetn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_serial;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    always_comb begin
        rx_sync = sync_q;
        fall    = ~sync_q & prev_q;
    end

endmodule

// File: rtl/rx_datapath.sv
// Serial-side UART receive datapath: start detect, LSB-first shifting, parity and
// stop checking, and a valid/ready holding register for completed bytes.

module rx_datapath
    import rx_datapath_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned PARITY_ODD = DefaultParityOdd
) (
    input  logic                  rx_clk,
    input  logic                  resetn,
    input  logic                  rx_serial,
    input  logic                  shift,
    input  logic                  parity_load,
    input  logic                  check_stop,
    output logic                  start_bit_detected,
    output logic                  parity_bit_error,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  framing_error,
    output logic                  overrun_error
);

    localparam logic OddParity = (PARITY_ODD != 0);

    logic rx_sync;
    logic fall;

    uart_rx_sync u_sync (
        .rx_clk    (rx_clk),
        .resetn    (resetn),
        .rx_serial (rx_serial),
        .rx_sync   (rx_sync),
        .fall      (fall)
    );

    logic                  start_q, start_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic                  par_acc_q, par_acc_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  framing_q, framing_d;
    logic                  overrun_q, overrun_d;

    logic busy;
    logic stop_ok;
    logic accept;
    logic load;

    always_comb begin
        // Any rx_fsm strobe, or the detect pulse itself, masks new start edges.
        busy    = shift | parity_load | check_stop | start_q;
        start_d = fall & ~busy;

        sreg_d = sreg_q;
        if (shift) begin
            sreg_d = {rx_sync, sreg_q[DATA_WIDTH-1:1]};
        end

        par_acc_d = par_acc_q;
        if (start_q) begin
            par_acc_d = 1'b0;
        end else if (shift) begin
            par_acc_d = par_acc_q ^ rx_sync;
        end

        stop_ok   = check_stop & rx_sync;
        framing_d = check_stop & ~rx_sync;
        accept    = ~rx_valid_q | rx_ready;
        load      = stop_ok & accept;
        overrun_d = stop_ok & ~accept;

        rx_valid_d = next_valid(rx_valid_q, rx_ready, load);
        rx_data_d  = load ? sreg_q : rx_data_q;
    end

    always_ff @(posedge rx_clk) begin
        if (!resetn) begin
            start_q    <= 1'b0;
            sreg_q     <= '0;
            par_acc_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            framing_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            start_q    <= start_d;
            sreg_q     <= sreg_d;
            par_acc_q  <= par_acc_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            framing_q  <= framing_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        start_bit_detected = start_q;
        parity_bit_error   = parity_load & parity_mismatch(par_acc_q, rx_sync, OddParity);
        rx_data            = rx_data_q;
        rx_valid           = rx_valid_q;
        framing_error      = framing_q;
        overrun_error      = overrun_q;
    end

endmodule

// File: tb/tb_rx_datapath.sv
// Self-checking bench for rx_datapath: the bench plays rx_fsm and the line driver,
// and a scoreboard queue holds the bytes the holding register must present.

module tb_rx_datapath;

    logic rx_clk      = 1'b0;
    logic resetn      = 1'b0;
    logic rx_serial   = 1'b1;
    logic shift       = 1'b0;
    logic parity_load = 1'b0;
    logic check_stop  = 1'b0;
    logic rx_ready    = 1'b0;
    logic sel_odd     = 1'b0;

    logic       e_sbd, e_perr, e_valid, e_fe, e_oe;
    logic [7:0] e_data;
    logic       o_sbd, o_perr, o_valid, o_fe, o_oe;
    logic [7:0] o_data;

    logic       obs_sbd, obs_perr, obs_valid, obs_fe, obs_oe;
    logic [7:0] obs_data;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  m_data = 8'h00;

    always #5 rx_clk = ~rx_clk;

    rx_datapath #(
        .DATA_WIDTH (8),
        .PARITY_ODD (0)
    ) u_dut_even (
        .rx_clk             (rx_clk),
        .resetn             (resetn),
        .rx_serial          (rx_serial),
        .shift              (shift),
        .parity_load        (parity_load),
        .check_stop         (check_stop),
        .start_bit_detected (e_sbd),
        .parity_bit_error   (e_perr),
        .rx_data            (e_data),
        .rx_valid           (e_valid),
        .rx_ready           (rx_ready),
        .framing_error      (e_fe),
        .overrun_error      (e_oe)
    );

    rx_datapath #(
        .DATA_WIDTH (8),
        .PARITY_ODD (1)
    ) u_dut_odd (
        .rx_clk             (rx_clk),
        .resetn             (resetn),
        .rx_serial          (rx_serial),
        .shift              (shift),
        .parity_load        (parity_load),
        .check_stop         (check_stop),
        .start_bit_detected (o_sbd),
        .parity_bit_error   (o_perr),
        .rx_data            (o_data),
        .rx_valid           (o_valid),
        .rx_ready           (rx_ready),
        .framing_error      (o_fe),
        .overrun_error      (o_oe)
    );

    always_comb begin
        obs_sbd   = sel_odd ? o_sbd   : e_sbd;
        obs_perr  = sel_odd ? o_perr  : e_perr;
        obs_valid = sel_odd ? o_valid : e_valid;
        obs_fe    = sel_odd ? o_fe    : e_fe;
        obs_oe    = sel_odd ? o_oe    : e_oe;
        obs_data  = sel_odd ? o_data  : e_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every cycle the holding register is valid it must show the head
    // byte; a transfer retires it.
    always @(negedge rx_clk) begin
        if (resetn && obs_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", 32'(obs_valid), 32'd0);
            end else begin
                check_eq("rx_data", 32'(obs_data), 32'(exp_q[0]));
                if (rx_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Line bits per cycle: idle x3, start x2 (covers detect-to-shift latency), data,
    // parity, stop, idle. rx_sync lags the line by two cycles, so strobes lag too.
    task automatic send_frame(input logic [7:0] data, input logic par_bit, input logic stop_bit,
                              input bit ready_pulse, input int abort_k);
        logic [17:0] line;
        logic        err;
        logic        ovr;
        line = '1;
        line[3] = 1'b0;
        line[4] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            line[5+i] = data[i];
        end
        line[13] = par_bit;
        line[14] = stop_bit;
        err = ((^data) ^ par_bit) != sel_odd;
        ovr = 1'b0;
        for (int k = 0; k < 18; k++) begin
            if (k == abort_k) begin
                return;
            end
            rx_serial   = line[k];
            shift       = (k >= 7) && (k <= 14);
            parity_load = (k == 15);
            check_stop  = (k == 16) && !err;
            if (ready_pulse) begin
                rx_ready = (k == 16);
            end
            if (k == 16 && !err && stop_bit) begin
                if (exp_q.size() == 0 || rx_ready) begin
                    exp_q.push_back(data);
                    m_data = data;
                end else begin
                    ovr = 1'b1;
                end
            end
            @(negedge rx_clk);
            check_eq("start_det", 32'(obs_sbd), 32'(k == 6));
            if (k == 15) begin
                check_eq("parity_err", 32'(obs_perr), 32'(err));
            end
            check_eq("framing_err", 32'(obs_fe), 32'(k == 17 && !err && !stop_bit));
            check_eq("overrun_err", 32'(obs_oe), 32'(k == 17 && ovr));
            if (k == 17) begin
                check_eq("rx_data_hold", 32'(obs_data), 32'(m_data));
            end
            @(posedge rx_clk);
            #1;
        end
    endtask

    task automatic accept_pending();
        rx_ready = 1'b1;
        @(negedge rx_clk);
        @(posedge rx_clk);
        #1;
        rx_ready = 1'b0;
        @(negedge rx_clk);
        check_eq("valid_cleared", 32'(obs_valid), 32'd0);
        @(posedge rx_clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn      = 1'b0;
        rx_serial   = 1'b1;
        shift       = 1'b0;
        parity_load = 1'b0;
        check_stop  = 1'b0;
        repeat (2) begin
            @(posedge rx_clk);
            #1;
        end
        @(negedge rx_clk);
        check_eq("rst_sbd_e", 32'(e_sbd), 32'd0);
        check_eq("rst_valid_e", 32'(e_valid), 32'd0);
        check_eq("rst_data_e", 32'(e_data), 32'd0);
        check_eq("rst_fe_e", 32'(e_fe), 32'd0);
        check_eq("rst_oe_e", 32'(e_oe), 32'd0);
        check_eq("rst_perr_e", 32'(e_perr), 32'd0);
        check_eq("rst_sbd_o", 32'(o_sbd), 32'd0);
        check_eq("rst_valid_o", 32'(o_valid), 32'd0);
        check_eq("rst_data_o", 32'(o_data), 32'd0);
        check_eq("rst_fe_o", 32'(o_fe), 32'd0);
        check_eq("rst_oe_o", 32'(o_oe), 32'd0);
        exp_q.delete();
        m_data = 8'h00;
        @(posedge rx_clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        @(posedge rx_clk);
        #1;
        apply_reset();

        // Good frame, then a parity-error copy that must leave the register alone.
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, -1);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, -1);

        // Odd-weight byte leaves par_acc set; the next frame relies on the clear.
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, -1);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, -1);

        // Framing error with nothing pending.
        rx_ready = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);

        // Overrun: second byte dropped while the first is unread.
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, -1);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, -1);
        accept_pending();

        // Second byte completes on the very cycle the first is accepted.
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, -1);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1, -1);
        accept_pending();

        // Reset after data bit 3, then an odd-parity frame on the odd instance.
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 11);
        apply_reset();
        sel_odd = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0, -1);
        repeat (2) begin
            @(posedge rx_clk);
            #1;
        end

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
